// File: rtl/cast_flit_sender.sv
// ---------------------------------------------------------------------------
// cast_flit_sender
//
// Packetiser in front of a router input port. Each packet starts with a head
// flit that carries STREAM_ID and no payload. It is followed by PKT_LEN-1
// payload flits: body flits, and the last one is typed tail. Flits leave
// through a single output register with a valid/ready handshake.
//
// Optional feature (macro CAST_SENDER_CREDIT_EN):
//   Defined    : a 32-bit credit counter tracks free downstream buffer slots.
//                A flit is loaded only while a credit is available.
//                credit_ret gives a credit back, saturating at CREDIT_INIT.
//   Undefined  : credit_ret is ignored. Flow control is valid/ready only.
//
// Parameters
//   STREAM_ID   : stream id placed in every head flit
//   PKT_LEN     : flits per packet including the head (2..1024)
//   CREDIT_INIT : downstream buffer depth in flits
//
// Ports
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset
//   valid_i    : a payload word is offered
//   data_i     : payload word, `DW-2 bits
//   ready_o    : the payload word is accepted this cycle
//   valid_o    : a flit is offered to the router
//   data_o     : the flit, `DW bits. The type sits in the top two bits.
//   ready_i    : the router accepts the flit
//   credit_ret : one-cycle pulse, one downstream slot freed
//   busy       : a packet is in progress or a flit is still unsent
// ---------------------------------------------------------------------------
`ifndef DW
`define DW 32
`endif
`ifndef STREAM_ID_L
`define STREAM_ID_L 0
`endif
`ifndef STREAM_ID_H
`define STREAM_ID_H 7
`endif
`ifndef CAST_ROUTER_BUFFER_DEPTH_LOG
`define CAST_ROUTER_BUFFER_DEPTH_LOG 2
`endif

module cast_flit_sender #(
    parameter int STREAM_ID   = 0,
    parameter int PKT_LEN     = 16,
    parameter int CREDIT_INIT = 2**`CAST_ROUTER_BUFFER_DEPTH_LOG
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid_i,
    input  logic [`DW-3:0]  data_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [`DW-1:0]  data_o,
    input  logic            ready_i,
    input  logic            credit_ret,
    output logic            busy
);

    localparam logic [1:0] FT_HEAD  = 2'b00;
    localparam logic [1:0] FT_BODY  = 2'b01;
    localparam logic [1:0] FT_TAIL  = 2'b10;
    localparam int         SID_W    = `STREAM_ID_H - `STREAM_ID_L + 1;
    localparam logic [9:0] LAST_IDX = 10'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t         state_reg;
    logic           valid_reg;
    logic [`DW-1:0] data_reg;
    logic [9:0]     flit_cnt_reg;
    logic           tail_loaded_reg;

    logic           credit_ok;
    logic           slot_free;
    logic           fire;
    logic           is_last;
    logic           head_load;
    logic           pay_load;
    logic           load;
    logic [`DW-1:0] head_flit;

    // The head flit has type 00 and the stream id. All other bits are zero.
    always_comb begin
        head_flit = '0;
        head_flit[`DW-1:`DW-2] = FT_HEAD;
        head_flit[`STREAM_ID_H:`STREAM_ID_L] = SID_W'(STREAM_ID);
    end

    assign fire      = valid_reg & ready_i;
    // The output register can take a new flit when it is empty, or when its
    // current flit leaves on this same edge.
    assign slot_free = ~valid_reg | ready_i;
    // flit_cnt_reg holds the number of flits already loaded. The next payload
    // flit is the tail when the count is PKT_LEN-1.
    assign is_last   = (flit_cnt_reg == LAST_IDX);

    // The head is loaded once per packet: flit_cnt_reg is zero only before it.
    assign head_load = (state_reg == HEAD) & (flit_cnt_reg == 10'd0)
                       & slot_free & credit_ok;
    // ready_o is combinational in ready_i. This lets a word be accepted
    // while the previous flit leaves, which gives 1 flit/cycle.
    assign ready_o   = (state_reg == PAYLOAD) & ~tail_loaded_reg
                       & slot_free & credit_ok;
    assign pay_load  = valid_i & ready_o;
    assign load      = head_load | pay_load;

    assign valid_o   = valid_reg;
    assign data_o    = data_reg;
    assign busy      = (state_reg != IDLE) | valid_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            valid_reg       <= 1'b0;
            data_reg        <= '0;
            flit_cnt_reg    <= 10'd0;
            tail_loaded_reg <= 1'b0;
        end else begin
            if (load) begin
                valid_reg <= 1'b1;
                data_reg  <= head_load ? head_flit
                                       : {(is_last ? FT_TAIL : FT_BODY), data_i};
            end else if (fire) begin
                valid_reg <= 1'b0;
            end

            // The counter clears when the tail is loaded, so it never has to
            // hold PKT_LEN. PKT_LEN=1024 would not fit in 10 bits.
            if (head_load) begin
                flit_cnt_reg <= 10'd1;
            end else if (pay_load) begin
                flit_cnt_reg <= is_last ? 10'd0 : flit_cnt_reg + 10'd1;
            end

            if (pay_load && is_last) begin
                tail_loaded_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        state_reg <= HEAD;
                    end
                end
                HEAD: begin
                    // In HEAD the output register can only hold the head flit.
                    if (fire) begin
                        state_reg <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // After the tail is loaded nothing else is loaded. So the
                    // flit that fires next is the tail. If data is already
                    // waiting, go straight to HEAD so busy stays high between
                    // back-to-back packets.
                    if (fire && tail_loaded_reg) begin
                        tail_loaded_reg <= 1'b0;
                        state_reg       <= valid_i ? HEAD : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef CAST_SENDER_CREDIT_EN
    logic [31:0] credit_cnt_reg;

    assign credit_ok = (credit_cnt_reg != 32'd0);

    // A load uses one credit and a return gives one back. When both happen
    // together they cancel. A return that would go above the buffer depth is
    // dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit_cnt_reg <= 32'(CREDIT_INIT);
        end else if (load && !credit_ret) begin
            credit_cnt_reg <= credit_cnt_reg - 32'd1;
        end else if (!load && credit_ret && (credit_cnt_reg < 32'(CREDIT_INIT))) begin
            credit_cnt_reg <= credit_cnt_reg + 32'd1;
        end
    end
`else
    logic unused_credit;

    assign credit_ok     = 1'b1;
    assign unused_credit = credit_ret | (CREDIT_INIT == 0);
`endif

endmodule
